uart_rx_ctrl: RTL and testbench

UART receiver front end and control unit, sitting directly downstream of the receiver `timer` block. It synchronizes the raw serial line and detects the start-bit falling edge. It drives `enable_timer`, consumes `shift_strobe`/`packet_done` to shift in data and stop bits, checks framing, and presents the received byte with ready/overrun/framing status to the host side.

---
 rtl/uart_rx_pkg.sv | 5 +
 rtl/start_bit_det.sv | 22 ++
 rtl/uart_rx_ctrl.sv | 66 ++++++
 tb/tb_uart_rx_ctrl.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: shared types and constants for the UART receive controller
package uart_rx_pkg;
  typedef enum logic [2:0] {IDLE, CLR, RECV, CHECK, LOAD} rx_state_t;
  localparam int UART_DATA_BITS = 8;
endpackage

// File: rtl/start_bit_det.sv
// start_bit_det: two-flop synchronizer on the RX line with falling-edge start detect
module start_bit_det (
  input  logic clk,
  input  logic rst,
  input  logic serial_in,
  output logic sync_out,
  output logic start_edge
);
  logic sync1, sync2, prev;
  always_ff @(posedge clk)
    if (rst) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      prev  <= 1'b1;
    end else begin
      sync1 <= serial_in;
      sync2 <= sync1;
      prev  <= sync2;
    end
  assign sync_out   = sync2;
  assign start_edge = prev & ~sync2;
endmodule

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: UART receive control FSM, shift register, output buffer and status flags
module uart_rx_ctrl
  import uart_rx_pkg::*;
#(
  parameter int DATA_BITS = UART_DATA_BITS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 serial_in,
  input  logic                 shift_strobe,
  input  logic                 packet_done,
  input  logic                 data_read,
  output logic                 enable_timer,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 data_ready,
  output logic                 overrun_error,
  output logic                 framing_error
);
  rx_state_t state, next_state;
  logic sync, start_edge, fe_pend;
  logic [DATA_BITS:0] sr;
  start_bit_det u_det (
    .clk        (clk),
    .rst        (rst),
    .serial_in  (serial_in),
    .sync_out   (sync),
    .start_edge (start_edge)
  );
  always_ff @(posedge clk)
    state <= rst ? IDLE : next_state;
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    next_state = start_edge ? CLR : IDLE;
      CLR:     next_state = RECV;
      RECV:    next_state = packet_done ? CHECK : RECV;
      CHECK:   next_state = sr[DATA_BITS] ? LOAD : IDLE;
      default: next_state = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (rst) begin
      enable_timer  <= 1'b0;
      sr            <= '1;
      rx_data       <= '1;
      data_ready    <= 1'b0;
      overrun_error <= 1'b0;
      framing_error <= 1'b0;
      fe_pend       <= 1'b0;
    end else begin
      enable_timer <= next_state == RECV;
      fe_pend      <= state == CHECK && !sr[DATA_BITS];
      if (state == CLR) sr <= '1;
      else if (state == RECV && shift_strobe) sr <= {sync, sr[DATA_BITS:1]};
      if (state == CLR) framing_error <= 1'b0;
      else if (fe_pend) framing_error <= 1'b1;
      if (state == LOAD) begin
        rx_data       <= sr[DATA_BITS-1:0];
        data_ready    <= 1'b1;
        overrun_error <= data_ready & ~data_read;
      end else if (data_read) begin
        data_ready    <= 1'b0;
        overrun_error <= 1'b0;
      end
    end
endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb_uart_rx_ctrl: directed and random frames checked against a frame-level model
module tb_uart_rx_ctrl;
  logic clk = 1'b0;
  logic rst, serial_in, shift_strobe, packet_done, data_read;
  logic enable_timer, data_ready, overrun_error, framing_error;
  logic [7:0] rx_data;
  int checks = 0;
  int errors = 0;
  logic [7:0] m_data;
  logic m_ready, m_ovr, m_fe;
  uart_rx_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .serial_in     (serial_in),
    .shift_strobe  (shift_strobe),
    .packet_done   (packet_done),
    .data_read     (data_read),
    .enable_timer  (enable_timer),
    .rx_data       (rx_data),
    .data_ready    (data_ready),
    .overrun_error (overrun_error),
    .framing_error (framing_error)
  );
  always #5 clk = ~clk;
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic chk_all(input string tag);
    chk({tag, ".rx_data"}, 32'(rx_data), 32'(m_data));
    chk({tag, ".data_ready"}, 32'(data_ready), 32'(m_ready));
    chk({tag, ".overrun"}, 32'(overrun_error), 32'(m_ovr));
    chk({tag, ".framing"}, 32'(framing_error), 32'(m_fe));
  endtask
  task automatic model_reset();
    m_data = 8'hFF;
    m_ready = 1'b0;
    m_ovr = 1'b0;
    m_fe = 1'b0;
  endtask
  task automatic host_read(input string tag);
    data_read = 1'b1;
    tick();
    data_read = 1'b0;
    m_ready = 1'b0;
    m_ovr = 1'b0;
    chk_all(tag);
  endtask
  task automatic frame(input string tag, input logic [7:0] d, input logic stop, input logic rd, input logic glitch);
    logic b;
    serial_in = 1'b0;
    tick(3);
    chk({tag, ".en_k2"}, 32'(enable_timer), 32'd0);
    tick();
    chk({tag, ".en_k3"}, 32'(enable_timer), 32'd1);
    m_fe = 1'b0;
    chk({tag, ".fe_clr"}, 32'(framing_error), 32'(m_fe));
    tick(2);
    for (int i = 0; i < 9; i++) begin
      b = (i < 8) ? d[i] : stop;
      if (glitch && i == 2) begin
        serial_in = 1'b0;
        tick();
      end
      serial_in = b;
      tick(3);
      shift_strobe = 1'b1;
      tick();
      shift_strobe = 1'b0;
    end
    serial_in = 1'b1;
    packet_done = 1'b1;
    tick();
    packet_done = 1'b0;
    chk({tag, ".en_check"}, 32'(enable_timer), 32'd0);
    tick();
    chk_all({tag, ".pre"});
    data_read = rd;
    tick();
    data_read = 1'b0;
    if (stop) begin
      m_ovr = rd ? 1'b0 : m_ready;
      m_ready = 1'b1;
      m_data = d;
    end else begin
      m_fe = 1'b1;
      if (rd) begin
        m_ready = 1'b0;
        m_ovr = 1'b0;
      end
    end
    chk_all({tag, ".post"});
  endtask
  initial begin
    rst = 1'b1;
    serial_in = 1'b1;
    shift_strobe = 1'b0;
    packet_done = 1'b0;
    data_read = 1'b0;
    model_reset();
    tick(2);
    rst = 1'b0;
    chk_all("reset");
    chk("reset.en", 32'(enable_timer), 32'd0);
    tick(2);
    frame("good_a5", 8'hA5, 1'b1, 1'b0, 1'b0);
    tick(2);
    frame("bad_3c", 8'h3C, 1'b0, 1'b0, 1'b0);
    tick(2);
    frame("after_bad", 8'h5A, 1'b1, 1'b0, 1'b0);
    host_read("read1");
    frame("ovr_11", 8'h11, 1'b1, 1'b0, 1'b0);
    frame("ovr_22", 8'h22, 1'b1, 1'b0, 1'b0);
    host_read("read2");
    frame("pre_77", 8'h55, 1'b1, 1'b0, 1'b0);
    frame("sim_77", 8'h77, 1'b1, 1'b1, 1'b0);
    frame("glitch", 8'hE7, 1'b1, 1'b0, 1'b1);
    shift_strobe = 1'b1;
    tick();
    shift_strobe = 1'b0;
    packet_done = 1'b1;
    tick();
    packet_done = 1'b0;
    tick(3);
    chk_all("idle_spurious");
    chk("idle_spurious.en", 32'(enable_timer), 32'd0);
    frame("after_spur", 8'hC3, 1'b1, 1'b0, 1'b0);
    serial_in = 1'b0;
    tick(6);
    shift_strobe = 1'b1;
    tick();
    shift_strobe = 1'b0;
    rst = 1'b1;
    serial_in = 1'b1;
    tick();
    model_reset();
    chk_all("mid_reset");
    chk("mid_reset.en", 32'(enable_timer), 32'd0);
    tick();
    rst = 1'b0;
    tick(3);
    chk_all("mid_reset.hold");
    for (int n = 0; n < 24; n++) begin
      frame($sformatf("rnd%0d", n), 8'($urandom), ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 2) == 0) host_read($sformatf("rnd_read%0d", n));
      tick($urandom_range(0, 3));
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
